// File: rtl/poly_note_generator_pkg.sv
// Shared constants and helpers for the polyphonic square-wave note generator.
// Sample format, amplitude step, saturation limits and channel-routing modes.
package poly_note_generator_pkg;

   localparam int SAMPLE_W  = 16;
   localparam int AMP_STEP  = 2048;
   localparam int AMP_SHIFT = $clog2(AMP_STEP);
   localparam int VOL_W     = 4;

   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

   typedef enum logic {
      MODE_MONO  = 1'b0,
      MODE_SPLIT = 1'b1
   } mix_mode_e;

   // Square-wave amplitude for one voice: high phase is +vol*AMP_STEP, low phase its negation.
   function automatic logic signed [SAMPLE_W-1:0] voice_amp(input logic [VOL_W-1:0] vol,
                                                            input logic phase);
      logic [SAMPLE_W-1:0] mag;
      mag = SAMPLE_W'(vol) << AMP_SHIFT;
      return phase ? signed'(mag) : -signed'(mag);
   endfunction

endpackage

// File: rtl/poly_note_generator_tone_voice.sv
// One square-wave voice: half-period counter, phase flip-flop and signed amplitude output.
// The amplitude is combinational from registered state; the mixer adds the output register.
module tone_voice
   import poly_note_generator_pkg::*;
#(
   parameter int DIV_W = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DIV_W-1:0]           note_div,
   input  logic                       voice_en,
   input  logic [VOL_W-1:0]           vol,
   input  logic                       sync,
   output logic signed [SAMPLE_W-1:0] contrib
);

   logic [DIV_W-1:0] cnt;
   logic             phase;
   logic             active;
   logic             wrap;

   assign active = voice_en && (note_div >= DIV_W'(2));
   // >= rather than == so that shrinking note_div below cnt wraps at once instead of running out.
   assign wrap   = (cnt >= (note_div - DIV_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (sync || !active) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (wrap) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + DIV_W'(1);
      end
   end

   assign contrib = active ? voice_amp(vol, phase) : '0;

endmodule

// File: rtl/poly_note_generator.sv
// Polyphonic square-wave generator: NUM_VOICES tone_voice instances mixed into a
// saturated, registered stereo pair, either mono (all voices both sides) or split even/odd.
module poly_note_generator
   import poly_note_generator_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int DIV_W      = 20
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_VOICES*DIV_W-1:0]   note_div,
   input  logic [NUM_VOICES-1:0]         voice_en,
   input  logic [NUM_VOICES*VOL_W-1:0]   vol,
   input  logic                          mode,
   input  logic                          sync,
   output logic signed [SAMPLE_W-1:0]    audio_left,
   output logic signed [SAMPLE_W-1:0]    audio_right
);

   // One guard bit beyond the worst-case growth so the sum never wraps before saturation.
   localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;

   logic signed [SAMPLE_W-1:0] contrib [NUM_VOICES];
   logic signed [SUM_W-1:0]    sum_all;
   logic signed [SUM_W-1:0]    sum_even;
   logic signed [SUM_W-1:0]    sum_odd;
   logic signed [SAMPLE_W-1:0] next_left;
   logic signed [SAMPLE_W-1:0] next_right;

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      tone_voice #(
         .DIV_W (DIV_W)
      ) u_voice (
         .clk      (clk),
         .rst_n    (rst_n),
         .note_div (note_div[v*DIV_W +: DIV_W]),
         .voice_en (voice_en[v]),
         .vol      (vol[v*VOL_W +: VOL_W]),
         .sync     (sync),
         .contrib  (contrib[v])
      );
   end

   function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [SUM_W-1:0] s);
      if (s > SUM_W'(SAMPLE_MAX)) begin
         return SAMPLE_MAX;
      end else if (s < SUM_W'(SAMPLE_MIN)) begin
         return SAMPLE_MIN;
      end else begin
         return SAMPLE_W'(s);
      end
   endfunction

   always_comb begin
      sum_all  = '0;
      sum_even = '0;
      sum_odd  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         sum_all = sum_all + SUM_W'(contrib[i]);
         if ((i % 2) == 0) begin
            sum_even = sum_even + SUM_W'(contrib[i]);
         end else begin
            sum_odd  = sum_odd + SUM_W'(contrib[i]);
         end
      end
   end

   always_comb begin
      next_left  = saturate(sum_all);
      next_right = saturate(sum_all);
      if (mix_mode_e'(mode) == MODE_SPLIT) begin
         next_left  = saturate(sum_even);
         next_right = saturate(sum_odd);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         audio_left  <= '0;
         audio_right <= '0;
      end else begin
         audio_left  <= next_left;
         audio_right <= next_right;
      end
   end

endmodule

// File: tb/tb_poly_note_generator.sv
// Scoreboard bench for poly_note_generator: a level/duration model predicts each stereo
// sample, a monitor compares it against the DUT one clock later.
module tb_poly_note_generator;

   localparam int NV = 4;
   localparam int DW = 20;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NV*DW-1:0]    note_div;
   logic [NV-1:0]       voice_en;
   logic [NV*4-1:0]     vol;
   logic                mode;
   logic                sync;
   logic signed [15:0]  audio_left;
   logic signed [15:0]  audio_right;

   typedef struct {
      int l;
      int r;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int div_a   [NV];
   int vol_a   [NV];
   bit en_a    [NV];
   bit mode_a;
   int level   [NV];
   int elapsed [NV];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   poly_note_generator #(
      .NUM_VOICES (NV),
      .DIV_W      (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .note_div    (note_div),
      .voice_en    (voice_en),
      .vol         (vol),
      .mode        (mode),
      .sync        (sync),
      .audio_left  (audio_left),
      .audio_right (audio_right)
   );

   task automatic checkOutput(input string name, input logic signed [15:0] actual, input int expected);
      logic signed [15:0] e16;
      e16 = 16'(expected);
      n_checks++;
      if (actual !== e16) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int clamp16(input int s);
      if (s > 32767)  return 32767;
      if (s < -32768) return -32768;
      return s;
   endfunction

   // A voice sounds only when enabled with a half-period of at least two cycles.
   function automatic int voice_level(input int v);
      if (!en_a[v] || div_a[v] < 2) return 0;
      return (level[v] != 0) ? vol_a[v] * 2048 : -(vol_a[v] * 2048);
   endfunction

   task automatic reset_model();
      for (int v = 0; v < NV; v++) begin
         level[v]   = 0;
         elapsed[v] = 0;
      end
   endtask

   // Predict the sample this edge registers, then advance each voice by one cycle.
   task automatic model_step();
      int   all_s, even_s, odd_s;
      exp_t e;
      all_s = 0; even_s = 0; odd_s = 0;
      for (int v = 0; v < NV; v++) begin
         all_s += voice_level(v);
         if (v % 2 == 0) even_s += voice_level(v);
         else            odd_s  += voice_level(v);
      end
      if (mode_a) begin
         e.l = clamp16(even_s);
         e.r = clamp16(odd_s);
      end else begin
         e.l = clamp16(all_s);
         e.r = clamp16(all_s);
      end
      exp_q.push_back(e);
      for (int v = 0; v < NV; v++) begin
         if (sync || !en_a[v] || div_a[v] < 2) begin
            level[v]   = 0;
            elapsed[v] = 0;
         end else if (elapsed[v] + 1 >= div_a[v]) begin
            level[v]   = 1 - level[v];
            elapsed[v] = 0;
         end else begin
            elapsed[v] = elapsed[v] + 1;
         end
      end
   endtask

   task automatic drive_inputs();
      for (int v = 0; v < NV; v++) begin
         note_div[v*DW +: DW] = DW'(div_a[v]);
         vol[v*4 +: 4]        = 4'(vol_a[v]);
         voice_en[v]          = en_a[v];
      end
      mode = mode_a;
   endtask

   task automatic set_voice(input int v, input int d, input int vl, input bit en);
      div_a[v] = d;
      vol_a[v] = vl;
      en_a[v]  = en;
   endtask

   task automatic all_off();
      for (int v = 0; v < NV; v++) set_voice(v, 0, 0, 1'b0);
   endtask

   // Called at a falling edge; returns at a falling edge after n rising edges.
   task automatic applyStimulus(input int n, input bit pulse_sync);
      for (int i = 0; i < n; i++) begin
         sync = pulse_sync && (i == 0);
         drive_inputs();
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
      sync = 1'b0;
   endtask

   task automatic midtone_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      checkOutput({tag, "_left"},  audio_left,  0);
      checkOutput({tag, "_right"}, audio_right, 0);
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checkOutput("left",  audio_left,  mon_e.l);
         checkOutput("right", audio_right, mon_e.r);
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n  = 1'b1;
      sync   = 1'b0;
      mode_a = 1'b0;
      all_off();
      drive_inputs();
      reset_model();
      #1 rst_n = 1'b0;
      #1;
      checkOutput("reset_left",  audio_left,  0);
      checkOutput("reset_right", audio_right, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Voice 0 alone, mono: 4 cycles low, 4 high.
      set_voice(0, 4, 15, 1'b1);
      applyStimulus(24, 1'b0);

      // Mid-tone reset; first sample after release is the low phase.
      midtone_reset("midreset");
      applyStimulus(10, 1'b0);

      // All voices loud together: saturation both ways.
      for (int v = 0; v < NV; v++) set_voice(v, 10, 15, 1'b1);
      applyStimulus(45, 1'b1);

      // Split routing with unequal periods.
      all_off();
      mode_a = 1'b1;
      set_voice(0, 3, 8, 1'b1);
      set_voice(1, 5, 4, 1'b1);
      applyStimulus(32, 1'b1);

      // Shrink the period below the running count.
      all_off();
      mode_a = 1'b0;
      set_voice(0, 100, 15, 1'b1);
      applyStimulus(51, 1'b1);
      div_a[0] = 8;
      applyStimulus(30, 1'b0);

      // Degenerate periods stay silent.
      set_voice(0, 1, 15, 1'b1);
      applyStimulus(8, 1'b0);
      set_voice(0, 0, 15, 1'b1);
      applyStimulus(8, 1'b0);

      // Randomised voices, routing, sync pulses and one reset.
      for (int it = 0; it < 200; it++) begin
         for (int v = 0; v < NV; v++) begin
            if ($urandom_range(0, 3) == 0) div_a[v] = $urandom_range(0, 14);
            if ($urandom_range(0, 3) == 0) vol_a[v] = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) en_a[v]  = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 7) == 0) mode_a = ~mode_a;
         if (it == 100) midtone_reset("rand_reset");
         applyStimulus($urandom_range(2, 20), $urandom_range(0, 9) == 0);
      end

      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL drain: %0d samples outstanding, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/poly_note_generator.md
POLY_NOTE_GENERATOR -- requirements
Module: poly_note_generator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of square-wave voices (1..8).
REQ-002 SHALL have parameter DIV_W, default 20, width of each voice half-period divider.
REQ-003 SHALL have port clk  input  1  system clock; one clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port note_div  input  NUM_VOICES*DIV_W  per-voice half-period in clk cycles; voice i at bits [i*DIV_W +: DIV_W].
REQ-006 SHALL have port voice_en  input  NUM_VOICES  per-voice enable.
REQ-007 SHALL have port vol  input  NUM_VOICES*4  per-voice volume 0..15; voice i at bits [i*4 +: 4].
REQ-008 SHALL have port mode  input  1  0 = mono (all voices to both channels), 1 = split (even voices left, odd voices right).
REQ-009 SHALL have port sync  input  1  single-cycle pulse restarting all voices in phase.
REQ-010 SHALL have port audio_left  output  16  signed two's-complement left sample.
REQ-011 SHALL have port audio_right  output  16  signed two's-complement right sample.

Function
REQ-012 Each voice SHALL keep a DIV_W-bit counter cnt and a 1-bit phase.
REQ-013 Active voice (voice_en=1 and note_div>=2): if cnt >= note_div-1, cnt SHALL go to 0 and phase SHALL toggle; otherwise cnt increments by 1.
REQ-014 Output frequency SHALL therefore be f_clk/(2*note_div); each phase level lasts exactly note_div cycles.
REQ-015 The >= compare SHALL make a note_div decrease below the current cnt wrap on the next edge, never a 2^DIV_W-cycle run-out.
REQ-016 Inactive voice (voice_en=0 or note_div<2) SHALL hold cnt=0, phase=0 and contribute 0.
REQ-017 Active voice contribution SHALL be +vol*2048 when phase=1 and -(vol*2048) when phase=0; vol=0 contributes 0.
REQ-018 sync=1 SHALL force cnt=0, phase=0 in every voice on that edge, overriding wrap/toggle.
REQ-019 Mixing SHALL sum contributions at width 16+clog2(NUM_VOICES)+1 signed, then saturate to [-32768, 32767].
REQ-020 mode=0: both channels SHALL equal the saturated sum of all voices.
REQ-021 mode=1: audio_left SHALL mix even-index voices, audio_right odd-index voices; NUM_VOICES=1 gives audio_right=0.
REQ-022 audio_left/audio_right SHALL be registered; latency one clk from voice state (cnt/phase/enable/vol/mode) to output.
REQ-023 Changes to note_div, vol, voice_en, mode SHALL take effect without glitch beyond the one-cycle latency; no handshake.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear every cnt, phase, audio_left and audio_right to 0.
REQ-025 Reset asserted mid-note SHALL discard state; after release voices restart from cnt=0, phase=0.
REQ-026 First output after release with an active voice SHALL be -(vol*2048) for that voice.

Structure
REQ-027 Shared package SHALL hold SAMPLE_W=16, AMP_STEP=2048, SAMPLE_MAX/SAMPLE_MIN, MODE_MONO=0/MODE_SPLIT=1.
REQ-028 Per-voice counter/phase/amplitude logic SHALL be sub-module tone_voice, instantiated NUM_VOICES times by generate.
REQ-029 Mixer and saturation SHALL live in poly_note_generator; estimated total 150-250 lines of RTL.

Verification (NUM_VOICES=4, DIV_W=20)
REQ-030 Reset: rst_n=0 mid-tone -> both outputs 0 immediately, without waiting for clk.
REQ-031 Voice0 div=4 vol=15, rest off, mode 0 -> both outputs -30720 for 4 cycles, +30720 for 4 cycles, repeating.
REQ-032 All voices div=10 vol=15 plus sync pulse -> outputs saturate at -32768 for 10 cycles, then 32767 for 10 cycles.
REQ-033 mode 1, voice0 div=3 vol=8, voice1 div=5 vol=4 -> left toggles +/-16384 every 3 cycles; right toggles +/-8192 every 5 cycles.
REQ-034 Voice0 div=100, change to div=8 when cnt=50 -> phase toggles on next edge, then every 8 cycles.
REQ-035 Voice0 div=1 or div=0 with voice_en=1 vol=15 -> outputs stay 0.
